// File: rtl/register_bank_8x16_write_pkg.sv
// Shared sizing constants and the select decode helper for the register bank write side.
package register_bank_8x16_write_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;

    localparam logic [DATA_W-1:0] RESET_VAL_DEF = 16'h0000;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    // One-hot decode; an inactive enable forces all-zero regardless of sel (even X/Z).
    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic en, input reg_sel_t sel);
        onehot_dec = '0;
        if (en) begin
            onehot_dec[sel] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/register_bank_8x16_write_if.sv
// Write-port and register-readout bundle between the datapath and the register bank.
interface register_bank_8x16_write_if
    import register_bank_8x16_write_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    // we is a one-way request: there is no ready, every we=1 sampled on a rising
    // edge is committed on that edge, and wack reports it during the following cycle.
    logic                 we;
    logic                 s2;
    logic                 s1;
    logic                 s0;
    logic [WIDTH-1:0]     d;
    logic                 clr;
    logic [WIDTH-1:0]     q0;
    logic [WIDTH-1:0]     q1;
    logic [WIDTH-1:0]     q2;
    logic [WIDTH-1:0]     q3;
    logic [WIDTH-1:0]     q4;
    logic [WIDTH-1:0]     q5;
    logic [WIDTH-1:0]     q6;
    logic [WIDTH-1:0]     q7;
    logic                 wack;
    reg_sel_t             wsel;
    logic [NUM_REGS-1:0]  written;

    modport master (
        output we, s2, s1, s0, d, clr,
        input  q0, q1, q2, q3, q4, q5, q6, q7, wack, wsel, written
    );

    modport slave (
        input  we, s2, s1, s0, d, clr,
        output q0, q1, q2, q3, q4, q5, q6, q7, wack, wsel, written
    );

endinterface

// File: rtl/register_bank_8x16_write_decoder_3_to_8.sv
// Reusable 3-to-8 one-hot decoder with enable; output is all-zero while en is low.
module decoder_3_to_8
    import register_bank_8x16_write_pkg::*;
(
    input  logic                en,
    input  logic                s2,
    input  logic                s1,
    input  logic                s0,
    output logic [NUM_REGS-1:0] y
);

    assign y = onehot_dec(en, {s2, s1, s0});

endmodule

// File: rtl/register_bank_8x16_write.sv
// Eight-entry register bank write side with write acknowledge and per-register written flags.
// Optional REG_BANK_ZERO_REG_EN hardwires register 0 to zero and drops writes to it.
module register_bank_8x16_write
    import register_bank_8x16_write_pkg::*;
#(
    parameter int                WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = RESET_VAL_DEF
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    register_bank_8x16_write_if.slave     bus
);

`ifdef REG_BANK_ZERO_REG_EN
    localparam logic [NUM_REGS-1:0] WR_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
    localparam logic [NUM_REGS-1:0] WR_MASK = {NUM_REGS{1'b1}};
`endif

    reg_sel_t             sel;
    logic [NUM_REGS-1:0]  en;
    logic [NUM_REGS-1:0]  wr_en;
    logic [WIDTH-1:0]     regs [NUM_REGS];
    logic                 wack_r;
    reg_sel_t             wsel_r;
    logic [NUM_REGS-1:0]  written_r;

    assign sel = {bus.s2, bus.s1, bus.s0};

    decoder_3_to_8 u_dec (
        .en (bus.we),
        .s2 (bus.s2),
        .s1 (bus.s1),
        .s0 (bus.s0),
        .y  (en)
    );

    // Masked enables gate both storage and flags; wack/wsel follow the raw request.
    assign wr_en = en & WR_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
`ifdef REG_BANK_ZERO_REG_EN
            regs[0] <= '0;
`endif
            wack_r    <= 1'b0;
            wsel_r    <= '0;
            written_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= bus.d;
                end
            end
            wack_r <= bus.we;
            if (bus.we) begin
                wsel_r <= sel;
            end
            // Clear first, then OR in the written bit so a same-edge write survives clr.
            written_r <= (bus.clr ? '0 : written_r) | wr_en;
        end
    end

    assign bus.q0      = regs[0];
    assign bus.q1      = regs[1];
    assign bus.q2      = regs[2];
    assign bus.q3      = regs[3];
    assign bus.q4      = regs[4];
    assign bus.q5      = regs[5];
    assign bus.q6      = regs[6];
    assign bus.q7      = regs[7];
    assign bus.wack    = wack_r;
    assign bus.wsel    = wsel_r;
    assign bus.written = written_r;

endmodule

// File: tb/tb_register_bank_8x16_write.sv
// Bench for register_bank_8x16_write: reset, table-driven write sweep, corner sequences, random traffic.
module tb_register_bank_8x16_write;

`ifdef REG_BANK_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic clk;
    logic rst_n;

    register_bank_8x16_write_if #(.WIDTH(16)) bus ();

    register_bank_8x16_write #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] q_bus [8];
    assign q_bus[0] = bus.q0;
    assign q_bus[1] = bus.q1;
    assign q_bus[2] = bus.q2;
    assign q_bus[3] = bus.q3;
    assign q_bus[4] = bus.q4;
    assign q_bus[5] = bus.q5;
    assign q_bus[6] = bus.q6;
    assign q_bus[7] = bus.q7;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [15:0] m_q [8];
    logic        m_wack;
    logic [2:0]  m_wsel;
    logic [7:0]  m_written;

    int vectors;
    int miscompares;

    logic [15:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_q[i] = 16'h0000;
        m_wack    = 1'b0;
        m_wsel    = 3'b000;
        m_written = 8'h00;
    endtask

    task automatic model_edge(input logic we, input logic [2:0] sel, input logic [15:0] d,
                              input logic clr);
        if (clr) m_written = 8'h00;
        if (we) begin
            m_wsel = sel;
            if (!(ZERO_REG && sel == 3'd0)) begin
                m_q[sel]       = d;
                m_written[sel] = 1'b1;
            end
        end
        m_wack = we;
    endtask

    // ---------------- checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s q%0d", tag, i), {16'h0, q_bus[i]}, {16'h0, m_q[i]});
        end
        chk({tag, " wack"},    {31'h0, bus.wack},   {31'h0, m_wack});
        chk({tag, " wsel"},    {29'h0, bus.wsel},   {29'h0, m_wsel});
        chk({tag, " written"}, {24'h0, bus.written}, {24'h0, m_written});
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic we, input logic [2:0] sel, input logic [15:0] d,
                         input logic clr);
        bus.we  = we;
        {bus.s2, bus.s1, bus.s0} = sel;
        bus.d   = d;
        bus.clr = clr;
        @(posedge clk);
        model_edge(we, sel, d, clr);
        #1;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] d;
        logic [15:0] exp_qv;
        logic [7:0]  exp_written;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [2:0]  rsel;
        logic [15:0] popped;
        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{3'd0, 16'h00DE, 16'h00DE, 8'h01};
        tbl[1] = '{3'd1, 16'h00BC, 16'h00BC, 8'h03};
        tbl[2] = '{3'd2, 16'h009A, 16'h009A, 8'h07};
        tbl[3] = '{3'd3, 16'h0078, 16'h0078, 8'h0F};
        tbl[4] = '{3'd4, 16'h0056, 16'h0056, 8'h1F};
        tbl[5] = '{3'd5, 16'h0034, 16'h0034, 8'h3F};
        tbl[6] = '{3'd6, 16'h0012, 16'h0012, 8'h7F};
        tbl[7] = '{3'd7, 16'h00F0, 16'h00F0, 8'hFF};
        if (ZERO_REG) begin
            tbl[0].exp_qv = 16'h0000;
            for (int i = 0; i < 8; i++) tbl[i].exp_written = tbl[i].exp_written & 8'hFE;
        end

        bus.we = 1'b0; bus.s2 = 1'b0; bus.s1 = 1'b0; bus.s0 = 1'b0;
        bus.d = 16'h0; bus.clr = 1'b0;
        rst_n = 1'b1;

        // Asynchronous reset asserted between edges.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 8; i++) chk($sformatf("reset q%0d", i), {16'h0, q_bus[i]}, 32'h0);
        chk("reset wack",    {31'h0, bus.wack},    32'h0);
        chk("reset wsel",    {29'h0, bus.wsel},    32'h0);
        chk("reset written", {24'h0, bus.written}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Write all eight registers back to back.
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, tbl[i].sel, tbl[i].d, 1'b0);
            exp_q.push_back(tbl[i].exp_qv);
            chk($sformatf("sweep q[%0d]", i), {16'h0, q_bus[tbl[i].sel]}, {16'h0, tbl[i].exp_qv});
            chk($sformatf("sweep wack %0d", i), {31'h0, bus.wack}, 32'h1);
            chk($sformatf("sweep written %0d", i), {24'h0, bus.written}, {24'h0, tbl[i].exp_written});
            check_all("sweep");
        end
        chk("sweep wsel", {29'h0, bus.wsel}, 32'h7);
        for (int i = 0; i < 8; i++) begin
            popped = exp_q.pop_front();
            chk($sformatf("sweep final q%0d", i), {16'h0, q_bus[i]}, {16'h0, popped});
        end

        // Hold with random and unknown selects while we is low.
        for (int i = 0; i < 10; i++) begin
            rsel = 3'($urandom_range(0, 7));
            if (i % 3 == 0) rsel = 3'bx1z;
            apply(1'b0, rsel, 16'($urandom), 1'b0);
            chk("hold wack", {31'h0, bus.wack}, 32'h0);
            check_all("hold");
        end

        // Same register written on consecutive edges.
        apply(1'b1, 3'd5, 16'h1111, 1'b0);
        apply(1'b1, 3'd5, 16'h2222, 1'b0);
        chk("overwrite q5", {16'h0, bus.q5}, 32'h2222);
        check_all("overwrite");

        // Clear colliding with a write to register 2.
        apply(1'b1, 3'd2, 16'h5A5A, 1'b1);
        chk("clr+write written", {24'h0, bus.written}, 32'h04);
        check_all("clr");
        apply(1'b0, 3'd0, 16'h0, 1'b0);
        chk("post clr wack", {31'h0, bus.wack}, 32'h0);

        // Register 0 behaviour (zero register when the option is built in).
        apply(1'b1, 3'd0, 16'hFFFF, 1'b0);
        chk("r0 q0", {16'h0, bus.q0}, ZERO_REG ? 32'h0 : 32'hFFFF);
        chk("r0 wack", {31'h0, bus.wack}, 32'h1);
        chk("r0 wsel", {29'h0, bus.wsel}, 32'h0);
        chk("r0 written0", {31'h0, bus.written[0]}, ZERO_REG ? 32'h0 : 32'h1);
        apply(1'b1, 3'd1, 16'h0BEE, 1'b0);
        chk("r1 q1", {16'h0, bus.q1}, 32'h0BEE);
        check_all("r0");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 7) == 0));
            check_all("rand");
        end

        // Reset arriving while a write to register 3 is in flight.
        bus.we = 1'b1; {bus.s2, bus.s1, bus.s0} = 3'd3; bus.d = 16'hAAAA; bus.clr = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("midreset q3", {16'h0, bus.q3}, 32'h0);
        chk("midreset wack", {31'h0, bus.wack}, 32'h0);
        check_all("midreset");
        bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 3'd6, 16'hC0DE, 1'b0);
        chk("post reset q6", {16'h0, bus.q6}, 32'hC0DE);
        check_all("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
